mem_port_arb: RTL and testbench
===============================

// Module: mem_port_arb
// PURPOSE
//  Arbitrates two requesters, m0 = CPU data port and m1 = aux loader/debug, onto the shared
//  write port and read port B of the 4-lane byte-banked data RAM. Port A stays reserved for fetch.
//  Converts byte/half/word accesses into per-lane write enables and aligned read data.
//  Flags misaligned accesses. Grants at most one access per cycle.
// PARAMETERS
//  AW  11  word-address width of each RAM bank (bank depth 2**AW bytes)
// PORTS
//  clock          in   1      system clock, all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  mN_req         in   1      N=0,1: access request, held until mN_gnt
//  mN_we          in   1      1=store, 0=load
//  mN_addr        in   AW+2   byte address; [1:0] = byte offset
//  mN_size        in   2      00 byte, 01 half, 10 word, 11 illegal
//  mN_wdata       in   32     store data, right-justified
//  mN_gnt         out  1      request accepted this cycle (combinational)
//  mN_rvalid      out  1      load data valid (1 cycle after gnt)
//  mN_rdata       out  32     load data, right-justified, zero-extended
//  mN_err         out  1      misaligned/illegal pulse (1 cycle after gnt)
//  ram_wraddress  out  AW     word address to all banks, write port
//  ram_rdaddress  out  AW     word address to all banks, read port B
//  ram_data       out  32     lane3=[31:24] ... lane0=[7:0]
//  ram_wren       out  4      per-lane write enable, bit i -> bank i
//  ram_q          in   32     bank qb outputs concatenated, lane3..lane0
// BEHAVIOUR
//  - Reset: all outputs 0; grant pointer favours m0; pending-read/err pipeline cleared.
//  - Byte order is big-endian: offset b selects lane 3-b. Half at offset 0 uses lanes 3:2; at offset 2 uses lanes 1:0.
//  - Arbitration is per cycle. A single requester is granted immediately. On contention the winner follows the pointer.
//    The pointer toggles to the loser after each contended grant.
//  - Granted store: ram_wraddress=addr[AW+1:2]; the byte/half is replicated into the selected lanes; ram_wren = lane mask.
//    All of this is driven in the gnt cycle. The banks register it and commit at the following edge.
//  - Granted load: ram_rdaddress=addr[AW+1:2] in the gnt cycle.
//    The requester id, offset and size are registered. Next cycle: mN_rvalid=1.
//    mN_rdata is extracted combinationally from ram_q and zero-extended.
//  - Store-then-load to the same word on consecutive grants returns the new data; no forwarding is needed.
//  - Misaligned or illegal access: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    The request is granted (consumed) and no RAM access occurs (ram_wren=0).
//    mN_err pulses 1 cycle later. rvalid stays 0.
//  - ram_wren is 0 in every cycle without a valid store grant. ram_rdaddress holds its last value when idle.
//  - rst asserted mid-operation: a pending rvalid/err is dropped, wren is forced 0 in the rst cycle,
//    and the pointer returns to m0.
//  - A non-granted requester must hold req and its fields stable. gnt does not depend on its own outputs.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN
//   defined: round-robin pointer as above.
//   undefined: fixed priority, m0 always wins; m1 is granted only when m0_req=0. The pointer flop is removed.
// TESTING
//  1. m0 word store addr 0x010 data 0x12345678 -> m0_gnt=1, ram_wren=1111, ram_wraddress=4, ram_data=0x12345678.
//     Then word load 0x010 -> m0_rvalid next cycle, m0_rdata=0x12345678.
//  2. m0 byte store addr 0x013 data 0xAB -> ram_wren=0001, ram_data[7:0]=0xAB.
//     Byte load 0x013 -> rdata=0x000000AB. Byte load 0x010 -> 0x00000012.
//  3. m1 half store addr 0x012 data 0xBEEF -> ram_wren=0011.
//     Half load 0x012 -> m1_rdata=0x0000BEEF. Lanes 3:2 still read 0x1234.
//  4. m0_req and m1_req both held high for 6 cycles.
//     RR_EN defined -> grants m0,m1,m0,m1,m0,m1. Undefined -> m0 every cycle, m1_gnt=0.
//  5. m0 half load addr 0x011 -> m0_gnt=1, ram_wren=0, m0_err=1 next cycle, m0_rvalid=0. Same for size=11.
//  6. rst=1 the cycle after an m1 load grant -> m1_rvalid stays 0; all outputs 0 while rst=1.

Source files
------------

// File: rtl/mem_port_arb.sv
// Two-master arbiter onto the shared data-RAM write port and read port B, with byte/half/word lane steering.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for a round-robin pointer; otherwise m0 has fixed priority.
module mem_port_arb #(
    parameter int AW = 11
) (
    input  logic            clock,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW+1:0]   m0_addr,
    input  logic [1:0]      m0_size,
    input  logic [31:0]     m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [31:0]     m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW+1:0]   m1_addr,
    input  logic [1:0]      m1_size,
    input  logic [31:0]     m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [31:0]     m1_rdata,
    output logic            m1_err,

    output logic [AW-1:0]   ram_wraddress,
    output logic [AW-1:0]   ram_rdaddress,
    output logic [31:0]     ram_data,
    output logic [3:0]      ram_wren,
    input  logic [31:0]     ram_q
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic            req0;
    logic            req1;
    logic            gnt0;
    logic            gnt1;

    // Requests are ignored while reset is held so nothing is granted or written.
    assign req0 = m0_req & ~rst;
    assign req1 = m1_req & ~rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_reg;
    logic ptr_next;

    // ptr_reg names the master that wins the next contended cycle (0 = m0).
    always_comb begin
        gnt0     = req0 & (~req1 | ~ptr_reg);
        gnt1     = req1 & (~req0 |  ptr_reg);
        ptr_next = ptr_reg;
        if (req0 && req1) begin
            ptr_next = ~ptr_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`endif

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    logic            any_gnt;
    logic            sel_we;
    logic [AW+1:0]   sel_addr;
    logic [1:0]      sel_size;
    logic [31:0]     sel_wdata;
    logic [1:0]      offset;
    logic [AW-1:0]   word_addr;
    logic            misalign;
    logic            access_ok;
    logic            store_ok;
    logic            load_ok;

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? m1_we    : m0_we;
    assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
    assign sel_size  = gnt1 ? m1_size  : m0_size;
    assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign offset    = sel_addr[1:0];
    assign word_addr = sel_addr[AW+1:2];

    always_comb begin
        misalign = 1'b1;
        unique case (sel_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = offset[0];
            SZ_WORD: misalign = (offset != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign access_ok = any_gnt & ~misalign;
    assign store_ok  = access_ok &  sel_we;
    assign load_ok   = access_ok & ~sel_we;

    logic [3:0]      lane_sel;
    logic [31:0]     wr_word;
    logic [7:0]      rd_lane [4];

    // Big-endian lanes: byte offset b lives in lane 3-b; odd lanes carry the high byte of a half.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] BYTE_OFF    = 2'(3 - gi);
        localparam logic       IN_LOW_HALF = (gi < 2);

        assign lane_sel[gi] = (sel_size == SZ_BYTE) ? (offset == BYTE_OFF) :
                              (sel_size == SZ_HALF) ? (offset[1] == IN_LOW_HALF) :
                              (sel_size == SZ_WORD);

        assign wr_word[8*gi +: 8] = (sel_size == SZ_BYTE) ? sel_wdata[7:0] :
                                    (sel_size == SZ_HALF) ? ((gi % 2 == 1) ? sel_wdata[15:8]
                                                                           : sel_wdata[7:0]) :
                                    sel_wdata[8*gi +: 8];

        assign rd_lane[gi] = ram_q[8*gi +: 8];
    end

    assign ram_wren      = store_ok ? lane_sel  : 4'b0000;
    assign ram_wraddress = store_ok ? word_addr : '0;
    assign ram_data      = store_ok ? wr_word   : 32'h0;

    logic [AW-1:0]   rdaddr_reg;
    logic [1:0]      rvalid_reg;
    logic [1:0]      rvalid_next;
    logic [1:0]      err_reg;
    logic [1:0]      err_next;
    logic [1:0]      rd_off_reg;
    logic [1:0]      rd_size_reg;

    assign ram_rdaddress = rst ? '0 : (load_ok ? word_addr : rdaddr_reg);

    always_comb begin
        rvalid_next = 2'b00;
        err_next    = 2'b00;
        rvalid_next[0] = load_ok & gnt0;
        rvalid_next[1] = load_ok & gnt1;
        err_next[0]    = gnt0 & misalign;
        err_next[1]    = gnt1 & misalign;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rdaddr_reg  <= '0;
            rvalid_reg  <= 2'b00;
            err_reg     <= 2'b00;
            rd_off_reg  <= 2'b00;
            rd_size_reg <= 2'b00;
        end else begin
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
            if (load_ok) begin
                rdaddr_reg  <= word_addr;
                rd_off_reg  <= offset;
                rd_size_reg <= sel_size;
            end
        end
    end

    logic [31:0]     rd_word;

    // The offset-to-lane map 3-b is simply the bitwise inverse of a 2-bit offset.
    always_comb begin
        rd_word = 32'h0;
        unique case (rd_size_reg)
            SZ_BYTE: rd_word = {24'h0, rd_lane[~rd_off_reg]};
            SZ_HALF: rd_word = rd_off_reg[1] ? {16'h0, ram_q[15:0]} : {16'h0, ram_q[31:16]};
            SZ_WORD: rd_word = ram_q;
            default: rd_word = 32'h0;
        endcase
    end

    assign m0_rvalid = rvalid_reg[0] & ~rst;
    assign m1_rvalid = rvalid_reg[1] & ~rst;
    assign m0_err    = err_reg[0] & ~rst;
    assign m1_err    = err_reg[1] & ~rst;
    assign m0_rdata  = m0_rvalid ? rd_word : 32'h0;
    assign m1_rdata  = m1_rvalid ? rd_word : 32'h0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a behavioural 4-bank byte RAM (registered write and read).
module tb_mem_port_arb;

    localparam int AW = 11;

    logic            clock = 1'b0;
    logic            rst   = 1'b1;
    logic            m0_req = 1'b0, m0_we = 1'b0;
    logic [AW+1:0]   m0_addr = '0;
    logic [1:0]      m0_size = 2'b00;
    logic [31:0]     m0_wdata = 32'h0;
    logic            m1_req = 1'b0, m1_we = 1'b0;
    logic [AW+1:0]   m1_addr = '0;
    logic [1:0]      m1_size = 2'b00;
    logic [31:0]     m1_wdata = 32'h0;
    logic            m0_gnt, m0_rvalid, m0_err;
    logic            m1_gnt, m1_rvalid, m1_err;
    logic [31:0]     m0_rdata, m1_rdata;
    logic [AW-1:0]   ram_wraddress, ram_rdaddress;
    logic [31:0]     ram_data;
    logic [3:0]      ram_wren;
    logic [31:0]     ram_q = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_port_arb #(.AW(AW)) dut (
        .clock(clock), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_wraddress(ram_wraddress), .ram_rdaddress(ram_rdaddress),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    logic [7:0] bank [4][2**AW];

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_wren[i]) bank[i][ram_wraddress] <= ram_data[8*i +: 8];
            ram_q[8*i +: 8] <= bank[i][ram_rdaddress];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic set_req(input int m, input logic we, input logic [12:0] addr,
                           input logic [1:0] sz, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_size = sz; m0_wdata = wd;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_size = sz; m1_wdata = wd;
        end
    endtask

    task automatic do_store(input int m, input logic [12:0] addr, input logic [1:0] sz,
                            input logic [31:0] wd, input logic [3:0] exp_wren,
                            input logic [31:0] exp_data, input logic [31:0] dmask);
        logic [12:0] a;
        a = addr;
        @(negedge clock);
        clear_req();
        set_req(m, 1'b1, addr, sz, wd);
        #1;
        check_val("store_gnt", (m == 0) ? m0_gnt : m1_gnt, 32'd1);
        check_val("store_wren", {28'h0, ram_wren}, {28'h0, exp_wren});
        check_val("store_wraddr", {21'h0, ram_wraddress}, {21'h0, a[12:2]});
        check_val("store_data", ram_data & dmask, exp_data);
        $display("store m%0d addr=0x%03h size=%0d wdata=0x%08h wren=%b", m, addr, sz, wd, ram_wren);
    endtask

    task automatic do_load(input int m, input logic [12:0] addr, input logic [1:0] sz,
                           input logic [31:0] exp_rdata);
        logic [12:0] a;
        a = addr;
        @(negedge clock);
        clear_req();
        set_req(m, 1'b0, addr, sz, 32'h0);
        #1;
        check_val("load_gnt", (m == 0) ? m0_gnt : m1_gnt, 32'd1);
        check_val("load_wren", {28'h0, ram_wren}, 32'h0);
        check_val("load_rdaddr", {21'h0, ram_rdaddress}, {21'h0, a[12:2]});
        @(negedge clock);
        clear_req();
        #1;
        check_val("load_rvalid", (m == 0) ? m0_rvalid : m1_rvalid, 32'd1);
        check_val("load_rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
        check_val("load_err", (m == 0) ? m0_err : m1_err, 32'd0);
        check_val("idle_rdaddr_hold", {21'h0, ram_rdaddress}, {21'h0, a[12:2]});
        $display("load  m%0d addr=0x%03h size=%0d rdata=0x%08h", m, addr, sz,
                 (m == 0) ? m0_rdata : m1_rdata);
    endtask

    task automatic do_bad(input int m, input logic we, input logic [12:0] addr, input logic [1:0] sz);
        @(negedge clock);
        clear_req();
        set_req(m, we, addr, sz, 32'hFFFF_FFFF);
        #1;
        check_val("bad_gnt", (m == 0) ? m0_gnt : m1_gnt, 32'd1);
        check_val("bad_wren", {28'h0, ram_wren}, 32'h0);
        @(negedge clock);
        clear_req();
        #1;
        check_val("bad_err", (m == 0) ? m0_err : m1_err, 32'd1);
        check_val("bad_rvalid", (m == 0) ? m0_rvalid : m1_rvalid, 32'd0);
        $display("bad   m%0d we=%0d addr=0x%03h size=%0d err=%0d", m, we, addr, sz,
                 (m == 0) ? m0_err : m1_err);
    endtask

    initial begin
        logic exp0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
        check_val("rst_wren", {28'h0, ram_wren}, 32'h0);
        check_val("rst_rvalid_err", {28'h0, m1_err, m0_err, m1_rvalid, m0_rvalid}, 32'h0);
        check_val("rst_rdaddr", {21'h0, ram_rdaddress}, 32'h0);
        rst = 1'b0;

        // Word, byte and half accesses
        do_store(0, 13'h010, 2'b10, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'hFFFF_FFFF);
        do_load (0, 13'h010, 2'b10, 32'h1234_5678);
        do_store(0, 13'h013, 2'b00, 32'h0000_00AB, 4'b0001, 32'h0000_00AB, 32'h0000_00FF);
        do_load (0, 13'h013, 2'b00, 32'h0000_00AB);
        do_load (0, 13'h010, 2'b00, 32'h0000_0012);
        do_store(1, 13'h012, 2'b01, 32'h0000_BEEF, 4'b0011, 32'h0000_BEEF, 32'h0000_FFFF);
        do_load (1, 13'h012, 2'b01, 32'h0000_BEEF);
        do_load (1, 13'h010, 2'b01, 32'h0000_1234);
        do_load (1, 13'h010, 2'b10, 32'h1234_BEEF);

        // Contention for 6 cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            set_req(0, 1'b0, 13'h010, 2'b10, 32'h0);
            set_req(1, 1'b0, 13'h010, 2'b10, 32'h0);
            #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp0 = (i % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            check_val("contend_m0_gnt", {31'h0, m0_gnt}, {31'h0, exp0});
            check_val("contend_m1_gnt", {31'h0, m1_gnt}, {31'h0, ~exp0});
            $display("contend cycle %0d m0_gnt=%0d m1_gnt=%0d", i, m0_gnt, m1_gnt);
        end
        @(negedge clock);
        clear_req();

        // Misaligned and illegal accesses
        do_bad(0, 1'b0, 13'h011, 2'b01);
        do_bad(0, 1'b0, 13'h010, 2'b11);
        do_bad(1, 1'b1, 13'h012, 2'b10);

        // One contended grant to m0 moves a round-robin pointer to m1
        @(negedge clock);
        set_req(0, 1'b0, 13'h010, 2'b10, 32'h0);
        set_req(1, 1'b0, 13'h010, 2'b10, 32'h0);
        #1;
        check_val("pre_rst_m0_gnt", {31'h0, m0_gnt}, 32'd1);
        $display("contend pre-reset m0_gnt=%0d m1_gnt=%0d", m0_gnt, m1_gnt);

        // m1 load, then reset in the following cycle
        @(negedge clock);
        clear_req();
        set_req(1, 1'b0, 13'h010, 2'b10, 32'h0);
        #1;
        check_val("rst_case_m1_gnt", {31'h0, m1_gnt}, 32'd1);
        @(negedge clock);
        rst = 1'b1;
        clear_req();
        set_req(0, 1'b1, 13'h010, 2'b10, 32'hDEAD_BEEF);
        #1;
        check_val("midrst_m1_rvalid", {31'h0, m1_rvalid}, 32'd0);
        check_val("midrst_m1_rdata", m1_rdata, 32'h0);
        check_val("midrst_m0_gnt", {31'h0, m0_gnt}, 32'd0);
        check_val("midrst_wren", {28'h0, ram_wren}, 32'h0);
        check_val("midrst_rdaddr", {21'h0, ram_rdaddress}, 32'h0);
        $display("reset mid-op m1_rvalid=%0d wren=%b", m1_rvalid, ram_wren);
        @(negedge clock);
        rst = 1'b0;
        clear_req();
        set_req(0, 1'b0, 13'h010, 2'b10, 32'h0);
        set_req(1, 1'b0, 13'h010, 2'b10, 32'h0);
        #1;
        check_val("post_rst_m0_gnt", {31'h0, m0_gnt}, 32'd1);
        check_val("post_rst_m1_gnt", {31'h0, m1_gnt}, 32'd0);
        check_val("post_rst_m1_rvalid", {31'h0, m1_rvalid}, 32'd0);
        $display("contend post-reset m0_gnt=%0d m1_gnt=%0d", m0_gnt, m1_gnt);
        @(negedge clock);
        clear_req();
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
